// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, keeps at most one instruction-memory request in flight, and
// presents fetched words in IF/ID. Follows the hazard unit's pc_write /
// IF_ID_write stalls and flushes on redirects resolved in ID.
// Optional build macro: FETCH_PERF_CNT_EN adds saturating stall and flush
// counters on perf_stall_cycles / perf_flush_count.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | leaving reset, nothing issued yet
// REQ    | request presented on imem_req_*, waiting for ready
// WAIT   | request accepted, waiting for the in-order response
// HOLD   | response captured in hold buffer, IF/ID stalled

module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        pc_write,
   input  logic        IF_ID_write,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        if_id_valid,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc_plus4,
   output logic [31:0] if_id_instr,
   output logic        fetch_busy
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_stall_cycles,
   output logic [31:0] perf_flush_count
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] pc;
   logic [31:0] pc_next;
   logic [31:0] pc_plus4;
   logic [31:0] redir_pc;
   logic        kill;
   logic [31:0] hold_data;
   logic        adv;
   logic        rsp_in_wait;
   logic        rsp_keep;
   logic        deliver;
   logic [31:0] deliver_instr;
   logic        enter_req;

   // Fetch datapath decisions shared by the FSM and the registers
   always_comb begin
      adv           = pc_write & IF_ID_write & ~redirect_valid;
      redir_pc      = redirect_pc & ~32'h0000_0003;
      pc_plus4      = pc + 32'd4;
      rsp_in_wait   = (state == S_WAIT) & imem_rsp_valid;
      // a response survives only if no redirect hit it before or during arrival
      rsp_keep      = rsp_in_wait & ~kill & ~redirect_valid;
      deliver       = (rsp_keep & adv) | ((state == S_HOLD) & adv);
      deliver_instr = (state == S_HOLD) ? hold_data : imem_rsp_data;
      if (redirect_valid)
         pc_next = redir_pc;
      else if (deliver)
         pc_next = pc_plus4;
      else
         pc_next = pc;
      enter_req     = (state_next == S_REQ) & (state != S_REQ);
   end

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         state <= S_IDLE;
      else
         state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: state_next = S_REQ;
         S_REQ:  if (imem_req_ready) state_next = S_WAIT;
         S_WAIT: if (imem_rsp_valid) state_next = (rsp_keep && !adv) ? S_HOLD : S_REQ;
         S_HOLD: if (adv || redirect_valid) state_next = S_REQ;
         default: state_next = S_IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      imem_req_valid = (state == S_REQ);
      fetch_busy     = (state == S_WAIT) | (state == S_HOLD);
   end

   // PC, request address, kill flag and hold buffer
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pc            <= RESET_PC;
         imem_req_addr <= RESET_PC;
         kill          <= 1'b0;
         hold_data     <= 32'h0000_0000;
      end else begin
         pc <= pc_next;
         // address is captured on entry to REQ and held until accepted
         if (enter_req)
            imem_req_addr <= pc_next;
         if (rsp_in_wait)
            kill <= 1'b0;
         else if (redirect_valid && ((state == S_REQ) || (state == S_WAIT)))
            kill <= 1'b1;
         if (rsp_keep && !adv)
            hold_data <= imem_rsp_data;
      end
   end

   // IF/ID pipeline register: redirect flushes, delivery loads, else bubble or hold
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         if_id_valid    <= 1'b0;
         if_id_pc       <= 32'h0000_0000;
         if_id_pc_plus4 <= 32'h0000_0000;
         if_id_instr    <= 32'h0000_0000;
      end else if (redirect_valid) begin
         if_id_valid <= 1'b0;
      end else if (deliver) begin
         if_id_valid    <= 1'b1;
         if_id_pc       <= pc;
         if_id_pc_plus4 <= pc_plus4;
         if_id_instr    <= deliver_instr;
      end else if (IF_ID_write) begin
         if_id_valid <= 1'b0;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   // Saturating performance counters
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         perf_stall_cycles <= 32'h0000_0000;
         perf_flush_count  <= 32'h0000_0000;
      end else begin
         if (if_id_valid && !IF_ID_write && (perf_stall_cycles != 32'hFFFF_FFFF))
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
         if (redirect_valid && (perf_flush_count != 32'hFFFF_FFFF))
            perf_flush_count <= perf_flush_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by
// randomized hazard/redirect/memory traffic against a transaction-level model.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        pc_write = 1'b0;
   logic        IF_ID_write = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready = 1'b0;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc_plus4;
   logic [31:0] if_id_instr;
   logic        fetch_busy;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_stall_cycles;
   logic [31:0] perf_flush_count;
`endif

   fetch_stage dut (
      .clk(clk), .rstn(rstn), .pc_write(pc_write), .IF_ID_write(IF_ID_write),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
      .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
      .if_id_pc_plus4(if_id_pc_plus4), .if_id_instr(if_id_instr), .fetch_busy(fetch_busy)
`ifdef FETCH_PERF_CNT_EN
      , .perf_stall_cycles(perf_stall_cycles), .perf_flush_count(perf_flush_count)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] instr;
   } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;

   // reference model state (fetch pointer, in-flight word, buffered word)
   logic [31:0] fp;
   bit          m_out, m_live, m_buf, m_dirty, m_ifv, prev_pending;
   logic [31:0] prev_addr, mem_addr;
   int          mem_wait, mem_lat;
   bit          rand_lat;
   logic        ifid_wr_q;

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return 32'h2000_0000 + (a >> 2) + 32'd1;
   endfunction

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      fp = 32'h0; m_out = 0; m_live = 0; m_buf = 0; m_dirty = 0; m_ifv = 0;
      prev_pending = 0; prev_addr = 32'h0; mem_wait = 0; mem_addr = 32'h0;
      exp_q.delete();
   endtask

   // One cycle: observe outputs, drive inputs, advance model over the coming edge
   task automatic drive_step(input logic pw, input logic iw, input logic rv,
                             input logic [31:0] rpc, input logic rdy, input bit spur);
      bit adv, deliver;
      if (imem_req_valid) begin
         if (prev_pending)
            check32("req_addr_stable", imem_req_addr, prev_addr);
         else begin
            check32("req_addr", imem_req_addr, fp);
            m_dirty = 0;
         end
      end
      check32("fetch_busy", {31'b0, fetch_busy}, {31'b0, (m_out | m_buf)});
      check32("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_ifv});
      prev_addr = imem_req_addr;

      pc_write = pw; IF_ID_write = iw; redirect_valid = rv; redirect_pc = rpc;
      imem_req_ready = rdy; imem_rsp_valid = 1'b0; imem_rsp_data = $urandom;
      if (mem_wait > 0) begin
         mem_wait--;
         if (mem_wait == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_fn(mem_addr);
         end
      end else if (spur && !m_out) begin
         imem_rsp_valid = 1'b1;
      end

      adv = pw & iw & ~rv;
      deliver = 0;
      if (m_out) begin
         if (imem_rsp_valid) begin
            m_out = 0;
            if (m_live && !rv) begin
               if (adv) deliver = 1;
               else     m_buf = 1;
            end
         end else if (rv) m_live = 0;
      end else if (m_buf) begin
         if (rv) m_buf = 0;
         else if (adv) begin deliver = 1; m_buf = 0; end
      end
      if (imem_req_valid) begin
         if (rv) m_dirty = 1;
         if (rdy) begin
            m_out = 1; m_live = !m_dirty; mem_addr = imem_req_addr;
            mem_wait = rand_lat ? int'($urandom_range(1, 3)) : mem_lat;
            prev_pending = 0;
         end else prev_pending = 1;
      end else prev_pending = 0;
      if (rv) begin
         fp = rpc & ~32'h3;
         m_ifv = 0;
      end else if (deliver) begin
         exp_q.push_back({fp, fp + 32'd4, mem_fn(fp)});
         fp = fp + 32'd4;
         m_ifv = 1;
      end else if (iw) m_ifv = 0;
   endtask

   task automatic do_cycle(input logic pw, input logic iw, input logic rv,
                           input logic [31:0] rpc, input logic rdy, input bit spur);
      @(negedge clk);
      drive_step(pw, iw, rv, rpc, rdy, spur);
   endtask

   task automatic peek();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check32({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'h0);
      check32({tag, "_req_addr"}, imem_req_addr, 32'h0);
      check32({tag, "_if_id_valid"}, {31'b0, if_id_valid}, 32'h0);
      check32({tag, "_if_id_pc"}, if_id_pc, 32'h0);
      check32({tag, "_if_id_pc4"}, if_id_pc_plus4, 32'h0);
      check32({tag, "_if_id_instr"}, if_id_instr, 32'h0);
      check32({tag, "_busy"}, {31'b0, fetch_busy}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
      check32({tag, "_perf_stall"}, perf_stall_cycles, 32'h0);
      check32({tag, "_perf_flush"}, perf_flush_count, 32'h0);
`endif
   endtask

   // IF_ID_write high at an edge plus valid afterwards means a new instruction was loaded
   always @(posedge clk or negedge rstn) begin
      if (!rstn) ifid_wr_q <= 1'b0;
      else       ifid_wr_q <= IF_ID_write;
   end

   // Scoreboard monitor
   always @(negedge clk) begin
      if (rstn && ifid_wr_q && if_id_valid) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL if_id_unexpected: got pc %h instr %h, none expected", if_id_pc, if_id_instr);
         end else begin
            mon_e = exp_q.pop_front();
            if ({if_id_pc, if_id_pc_plus4, if_id_instr} !== mon_e) begin
               n_bad++;
               $display("FAIL if_id_entry: got pc %h pc4 %h instr %h expected pc %h pc4 %h instr %h",
                        if_id_pc, if_id_pc_plus4, if_id_instr, mon_e.pc, mon_e.pc4, mon_e.instr);
            end
         end
      end
   end

   initial begin
      model_reset();
      mem_lat = 1; rand_lat = 0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");

      // reset release and back-to-back fetches at 1-cycle latency
      @(negedge clk);
      rstn = 1'b1;
      drive_step(1, 1, 0, 32'h0, 1, 0);
      peek();
      check32("c1_req_valid", {31'b0, imem_req_valid}, 32'h1);
      check32("c1_req_addr", imem_req_addr, 32'h0);
      do_cycle(1, 1, 0, 32'h0, 1, 0);
      do_cycle(1, 1, 0, 32'h0, 1, 0);
      peek();
      check32("c2_if_id_pc", if_id_pc, 32'h0);
      check32("c2_if_id_instr", if_id_instr, 32'h2000_0001);
      check32("c3_req_valid", {31'b0, imem_req_valid}, 32'h1);
      check32("c3_req_addr", imem_req_addr, 32'h4);

      // stall for three cycles while the response arrives
      do_cycle(0, 0, 0, 32'h0, 1, 0);
      do_cycle(0, 0, 0, 32'h0, 1, 0);
      do_cycle(0, 0, 0, 32'h0, 1, 0);
      peek();
      check32("hold_busy", {31'b0, fetch_busy}, 32'h1);
      check32("hold_no_req", {31'b0, imem_req_valid}, 32'h0);
      check32("hold_if_id_pc", if_id_pc, 32'h0);
      check32("hold_if_id_instr", if_id_instr, 32'h2000_0001);
      do_cycle(1, 1, 0, 32'h0, 1, 0);
      peek();
      check32("release_if_id_pc", if_id_pc, 32'h4);
      check32("release_if_id_instr", if_id_instr, 32'h2000_0002);
      check32("release_req_addr", imem_req_addr, 32'h8);
`ifdef FETCH_PERF_CNT_EN
      check32("perf_stall_3", perf_stall_cycles, 32'd3);
`endif

      // redirect while waiting on memory
      mem_lat = 2;
      do_cycle(1, 1, 0, 32'h0, 1, 0);
      do_cycle(1, 1, 1, 32'h0000_0103, 1, 0);
      peek();
      check32("wait_redir_if_id_valid", {31'b0, if_id_valid}, 32'h0);
      do_cycle(1, 1, 0, 32'h0, 1, 0);
      peek();
      check32("wait_redir_req_addr", imem_req_addr, 32'h0000_0100);
      mem_lat = 1;
      do_cycle(1, 1, 0, 32'h0, 1, 0);
      do_cycle(1, 1, 0, 32'h0, 1, 0);

      // redirect while the request is not yet accepted
      do_cycle(1, 1, 1, 32'h0000_0200, 0, 0);
      peek();
      check32("req_redir_addr_k", imem_req_addr, 32'h0000_0104);
      do_cycle(1, 1, 0, 32'h0, 0, 0);
      peek();
      check32("req_redir_addr_k1", imem_req_addr, 32'h0000_0104);
      do_cycle(1, 1, 0, 32'h0, 1, 0);
      do_cycle(1, 1, 0, 32'h0, 1, 0);
      peek();
      check32("req_redir_target", imem_req_addr, 32'h0000_0200);
`ifdef FETCH_PERF_CNT_EN
      check32("perf_flush_2", perf_flush_count, 32'd2);
`endif

      // top-of-address-space wrap (redirect with same-cycle acceptance)
      do_cycle(1, 1, 1, 32'hFFFF_FFFF, 1, 0);
      do_cycle(1, 1, 0, 32'h0, 1, 0);
      peek();
      check32("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
      do_cycle(1, 1, 0, 32'h0, 1, 0);
      do_cycle(1, 1, 0, 32'h0, 1, 0);
      peek();
      check32("wrap_if_id_pc", if_id_pc, 32'hFFFF_FFFC);
      check32("wrap_if_id_pc4", if_id_pc_plus4, 32'h0);
      check32("wrap_if_id_instr", if_id_instr, 32'h6000_0000);
      check32("wrap_next_req", imem_req_addr, 32'h0);

      // reset pulse while waiting, then a late response
      mem_lat = 3;
      do_cycle(1, 1, 0, 32'h0, 1, 0);
      do_cycle(1, 1, 0, 32'h0, 1, 0);
      #2;
      rstn = 1'b0;
      model_reset();
      #1;
      check_reset_outputs("midrst");
      @(negedge clk);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
      @(negedge clk);
      rstn = 1'b1;
      drive_step(1, 1, 0, 32'h0, 0, 1);
      do_cycle(1, 1, 0, 32'h0, 0, 1);
      peek();
      check32("late_rsp_req_valid", {31'b0, imem_req_valid}, 32'h1);
      check32("late_rsp_req_addr", imem_req_addr, 32'h0);
      check32("late_rsp_busy", {31'b0, fetch_busy}, 32'h0);

      // randomized traffic
      rand_lat = 1;
      for (int i = 0; i < 3000; i++) begin
         do_cycle(($urandom % 5) != 0, ($urandom % 5) != 0, ($urandom % 10) == 0,
                  $urandom, ($urandom % 4) != 0, ($urandom % 8) == 0);
      end
      @(posedge clk);
      @(negedge clk);
      #1;
      check32("scoreboard_drained", exp_q.size(), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS pipeline; it sits directly upstream of the hazard detection unit and ID stage. It owns the PC and issues one outstanding request at a time to instruction memory over a valid/ready request channel with a fixed-order response. It presents fetched instructions in the IF/ID register. It obeys the hazard unit's pc_write/IF_ID_write stall controls and flushes on taken branch/jump redirects resolved in ID.

## Interface
- RESET_PC, 32'h0000_0000, PC after reset; bits [1:0] must be 0.
- clk  in  1  clock, all state updates on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- pc_write  in  1  from hazard detection; 0 = PC must not advance.
- IF_ID_write  in  1  from hazard detection; 0 = IF/ID register holds.
- redirect_valid  in  1  taken branch/jump resolved in ID this cycle.
- redirect_pc  in  32  target; bits [1:0] forced to 0.
- imem_req_valid  out  1  fetch request.
- imem_req_addr  out  32  fetch address, registered.
- imem_req_ready  in  1  memory accepts request.
- imem_rsp_valid  in  1  response valid, ≥1 cycle after acceptance, in order.
- imem_rsp_data  in  32  instruction word.
- if_id_valid  out  1  IF/ID holds a real instruction (0 = bubble).
- if_id_pc  out  32  PC of IF/ID instruction.
- if_id_pc_plus4  out  32  if_id_pc + 4.
- if_id_instr  out  32  instruction.
- fetch_busy  out  1  high in WAIT or HOLD.

## Operation
- Reset values: state IDLE, pc=RESET_PC, imem_req_valid 0, imem_req_addr RESET_PC, kill 0, if_id_valid 0, if_id_pc 0, if_id_pc_plus4 0, if_id_instr 0 (NOP), fetch_busy 0, hold buffer empty.
- Advance condition adv = pc_write & IF_ID_write & !redirect_valid.
- IDLE: → REQ unconditionally.
- REQ: imem_req_valid=1, imem_req_addr=pc latched on entry; addr stable until accepted. valid&ready → WAIT.
- WAIT: on imem_rsp_valid: if kill or redirect_valid → drop, clear kill, → REQ. Else if adv → load IF/ID {valid=1, pc, pc+4, data}, pc<=pc+4, → REQ. Else → HOLD with data in hold buffer.
- HOLD: on adv → move buffer into IF/ID, pc<=pc+4, → REQ. On redirect_valid → discard buffer, → REQ.
- IF/ID with no instruction delivered: IF_ID_write=1 → if_id_valid<=0 (bubble), other fields unchanged; IF_ID_write=0 → hold all fields.
- Redirect (priority over pc_write/IF_ID_write): pc<=redirect_pc&~3, if_id_valid<=0. In REQ without ready: request kept as-is, kill<=1. In REQ with ready same cycle: → WAIT with kill=1. In WAIT: kill<=1 unless response arrives same cycle (dropped directly). In HOLD: buffer discarded.
- Next REQ after redirect uses redirected pc.
- PC arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- imem_rsp_valid outside WAIT ignored.
- rstn low mid-operation: all state to reset values immediately; any later response for the old request ignored (state not WAIT).

## Timing
- First request: imem_req_valid high in first cycle after rstn rises.
- Accept in cycle N, response N+1, adv=1: IF/ID valid after edge ending N+1; next request visible in N+2. Peak throughput 1 instruction / 2 cycles at 1-cycle memory latency.
- Redirect in cycle K: if_id_valid=0 after edge ending K; earliest request for target in K+1 (if no outstanding request).
- HOLD to IF/ID: one edge after adv rises.

## Configuration
- FETCH_PERF_CNT_EN defined: extra outputs perf_stall_cycles[31:0] (counts cycles with if_id_valid=1 & IF_ID_write=0) and perf_flush_count[31:0] (counts cycles with redirect_valid=1); both reset to 0, saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset release, ready=1, 1-cycle memory returning 0x2000_0001 at 0x0 and 0x2000_0002 at 0x4 -> requests 0x0 then 0x4 in cycles 1 and 3; IF/ID shows pc 0x0 instr 0x2000_0001, then pc 0x4.
- IF_ID_write=pc_write=0 for 3 cycles while response arrives -> state HOLD, IF/ID unchanged, pc unchanged; on release IF/ID loads held word one edge later.
- Redirect to 0x0000_0103 while in WAIT -> pending response dropped, if_id_valid=0, next request addr 0x0000_0100.
- Redirect in REQ with ready=0 for 2 cycles -> imem_req_addr stable, response after acceptance dropped, then request to target.
- pc=0xFFFF_FFFC fetch completes -> if_id_pc_plus4=0, next request 0x0.
- rstn pulsed low in WAIT -> all outputs reset values, late imem_rsp_valid ignored; with FETCH_PERF_CNT_EN, counters read 0.
